// File: rtl/cfg_shift_rx_pkg.sv
// Shared sizes, state encodings and helpers for the configuration shift receiver
// and the sequencer FSM that drives it.
package cfg_shift_rx_pkg;

    localparam int SIZESRSTAT_DEF  = 88;
    localparam int SIZESRDYN_DEF   = 16;
    localparam int SIZEADDRMUX_DEF = 7;

    localparam int CNT_W = 7;
    localparam int WD_W  = 8;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SHIFT_DYN  = 2'd1;
    localparam logic [1:0] ST_SHIFT_STAT = 2'd2;
    localparam logic [1:0] ST_HOLD       = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Terminal watchdog value: the HOLD cycle seeing this value is the 255th one.
    localparam logic [WD_W-1:0]  WD_LIMIT = 8'd254;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cfg_shift_rx_shift_capture.sv
// Serial-in shadow register with a saturating bit counter; clear wins over enable.
module shift_capture
    import cfg_shift_rx_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             sdi_i,
    output logic [W-1:0]     shadow_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (clr_i) begin
            shadow_d = '0;
            count_d  = '0;
        end else if (en_i) begin
            shadow_d = {shadow_q[W-2:0], sdi_i};
            count_d  = sat_inc(count_q);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    assign shadow_o = shadow_q;
    assign count_o  = count_q;

endmodule

// File: rtl/cfg_shift_rx.sv
// Receives dynamic and static configuration frames serially and commits them to the
// active registers only when a frame has exactly the right length.
module cfg_shift_rx
    import cfg_shift_rx_pkg::*;
#(
    parameter int SIZESRSTAT  = SIZESRSTAT_DEF,
    parameter int SIZESRDYN   = SIZESRDYN_DEF,
    parameter int SIZEADDRMUX = SIZEADDRMUX_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   sdi,
    input  logic                   sel_dyn,
    input  logic                   sel_stat,
    input  logic                   en_fin,
    output logic [SIZESRDYN-1:0]   dyn_q,
    output logic [SIZESRSTAT-1:0]  stat_q,
    output logic [SIZEADDRMUX-1:0] addr_mux,
    output logic                   dyn_valid,
    output logic                   stat_valid,
    output logic                   frame_err,
    output logic                   busy
);

    logic [1:0]            state_q, state_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  seen_q, seen_d;
    logic [SIZESRDYN-1:0]  dyn_word_q;
    logic [SIZESRSTAT-1:0] stat_word_q;
    logic                  dyn_valid_q, stat_valid_q, err_q;

    logic                  dyn_en, stat_en, clr;
    logic                  dyn_ld, stat_ld, err;
    logic [SIZESRDYN-1:0]  dyn_shadow;
    logic [SIZESRSTAT-1:0] stat_shadow;
    logic [CNT_W-1:0]      dyn_cnt, stat_cnt;

    shift_capture #(.W(SIZESRDYN)) u_cap_dyn (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en_i     (dyn_en),
        .clr_i    (clr),
        .sdi_i    (sdi),
        .shadow_o (dyn_shadow),
        .count_o  (dyn_cnt)
    );

    shift_capture #(.W(SIZESRSTAT)) u_cap_stat (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en_i     (stat_en),
        .clr_i    (clr),
        .sdi_i    (sdi),
        .shadow_o (stat_shadow),
        .count_o  (stat_cnt)
    );

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        seen_d  = seen_q;
        dyn_en  = 1'b0;
        stat_en = 1'b0;
        dyn_ld  = 1'b0;
        stat_ld = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The entry cycle already carries the first bit.
                if (sel_dyn && !en_fin) begin
                    dyn_en  = 1'b1;
                    state_d = ST_SHIFT_DYN;
                end else if (sel_stat && !sel_dyn) begin
                    stat_en = 1'b1;
                    state_d = ST_SHIFT_STAT;
                end
            end
            ST_SHIFT_DYN: begin
                if (sel_dyn) begin
                    dyn_en = 1'b1;
                end else if (sel_stat && dyn_cnt == CNT_W'(SIZESRDYN)) begin
                    dyn_ld  = 1'b1;
                    wd_d    = '0;
                    seen_d  = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_STAT: begin
                if (sel_dyn) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else if (sel_stat) begin
                    stat_en = 1'b1;
                end else if (stat_cnt == CNT_W'(SIZESRSTAT)) begin
                    stat_ld = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                seen_d = seen_q | en_fin;
                if (!en_fin && !sel_dyn) begin
                    state_d = ST_IDLE;
                end else if (!seen_q && !en_fin) begin
                    // Watchdog only runs while the sequencer has never acknowledged.
                    if (wd_q == WD_LIMIT) begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        clr = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            wd_q         <= '0;
            seen_q       <= 1'b0;
            dyn_word_q   <= '0;
            stat_word_q  <= '0;
            dyn_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            seen_q       <= seen_d;
            dyn_valid_q  <= dyn_ld;
            stat_valid_q <= stat_ld;
            err_q        <= err;
            if (dyn_ld)  dyn_word_q  <= dyn_shadow;
            if (stat_ld) stat_word_q <= stat_shadow;
        end
    end

    assign dyn_q      = dyn_word_q;
    assign stat_q     = stat_word_q;
    assign addr_mux   = dyn_word_q[SIZESRDYN-1 -: SIZEADDRMUX];
    assign dyn_valid  = dyn_valid_q;
    assign stat_valid = stat_valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cfg_shift_rx.sv
// Directed bench for cfg_shift_rx: a table of dynamic frames plus hand sequences
// for static frames, HOLD behaviour, watchdog, reset and back-to-back frames.
module tb_cfg_shift_rx;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         sdi, sel_dyn, sel_stat, en_fin;
    logic [15:0]  dyn_q;
    logic [87:0]  stat_q;
    logic [6:0]   addr_mux;
    logic         dyn_valid, stat_valid, frame_err, busy;

    int total = 0;
    int bad   = 0;
    int dv_cnt = 0, sv_cnt = 0, fe_cnt = 0;

    cfg_shift_rx dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .sdi        (sdi),
        .sel_dyn    (sel_dyn),
        .sel_stat   (sel_stat),
        .en_fin     (en_fin),
        .dyn_q      (dyn_q),
        .stat_q     (stat_q),
        .addr_mux   (addr_mux),
        .dyn_valid  (dyn_valid),
        .stat_valid (stat_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic [15:0] exp_dyn;
        logic [6:0]  exp_addr;
        logic        exp_ok;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge and count pulses.
    task automatic step(input logic d, input logic sd, input logic ss, input logic ef);
        sdi = d; sel_dyn = sd; sel_stat = ss; en_fin = ef;
        @(posedge CLK);
        #1;
        if (dyn_valid)  dv_cnt++;
        if (stat_valid) sv_cnt++;
        if (frame_err)  fe_cnt++;
    endtask

    task automatic send_dyn(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) step(data[i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_stat(input logic first, input int n);
        logic b;
        b = first;
        for (int i = 0; i < n; i++) begin
            step(b, 1'b0, 1'b1, 1'b0);
            b = ~b;
        end
    endtask

    initial begin
        int dv0, sv0, fe0;
        logic [87:0] pat_a, pat_5;
        pat_a = {22{4'hA}};
        pat_5 = {22{4'h5}};

        vt[0] = '{32'h0000_8001, 16, 16'h8001, 7'h40, 1'b1};
        vt[1] = '{32'h0000_1234, 15, 16'h8001, 7'h40, 1'b0};
        vt[2] = '{32'h0000_FFFF, 16, 16'hFFFF, 7'h7F, 1'b1};
        vt[3] = '{32'h0000_0000, 16, 16'h0000, 7'h00, 1'b1};
        vt[4] = '{32'h0000_A5C3, 16, 16'hA5C3, 7'h52, 1'b1};
        vt[5] = '{32'h0001_FFFF, 17, 16'hA5C3, 7'h52, 1'b0};

        RST_N = 1'b0; sdi = 0; sel_dyn = 0; sel_stat = 0; en_fin = 0;
        #1;
        check("reset dyn_q", dyn_q, 0);
        check("reset stat_q", stat_q, 0);
        check("reset flags", {dyn_valid, stat_valid, frame_err, busy}, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        RST_N = 1'b1;
        step(0, 0, 0, 0);

        // Dynamic frames: shift, strobe, acknowledge via en_fin, release.
        for (int i = 0; i < 6; i++) begin
            dv0 = dv_cnt; fe0 = fe_cnt;
            send_dyn(vt[i].data, vt[i].nbits);
            check($sformatf("v%0d busy shifting", i), busy, 1);
            step(0, 0, 1, 0);
            check($sformatf("v%0d dyn_valid", i), dyn_valid, vt[i].exp_ok);
            check($sformatf("v%0d frame_err", i), frame_err, !vt[i].exp_ok);
            check($sformatf("v%0d dyn_q", i), dyn_q, vt[i].exp_dyn);
            check($sformatf("v%0d addr_mux", i), addr_mux, vt[i].exp_addr);
            step(0, 0, 0, 1);
            step(0, 0, 0, 1);
            check($sformatf("v%0d busy in hold", i), busy, vt[i].exp_ok);
            step(0, 0, 0, 0);
            check($sformatf("v%0d busy released", i), busy, 0);
            check($sformatf("v%0d dyn_valid pulses", i), dv_cnt - dv0, vt[i].exp_ok ? 1 : 0);
            check($sformatf("v%0d frame_err pulses", i), fe_cnt - fe0, vt[i].exp_ok ? 0 : 1);
        end

        // en_fin high blocks a dynamic burst from starting in IDLE.
        step(1, 1, 0, 1);
        check("idle en_fin blocks entry", busy, 0);
        step(0, 0, 0, 0);

        // Static frames: 88 bits good, 89 bits error, 88 bits of 0101.. good.
        sv0 = sv_cnt;
        send_stat(1'b1, 88);
        check("stat busy shifting", busy, 1);
        step(0, 0, 0, 0);
        check("stat88 stat_q", stat_q, pat_a);
        check("stat88 stat_valid", stat_valid, 1);
        check("stat88 busy", busy, 0);
        check("stat88 pulses", sv_cnt - sv0, 1);
        step(0, 0, 0, 0);
        fe0 = fe_cnt; sv0 = sv_cnt;
        for (int i = 0; i < 89; i++) step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        check("stat89 frame_err", frame_err, 1);
        check("stat89 stat_q held", stat_q, pat_a);
        check("stat89 no valid", sv_cnt - sv0, 0);
        step(0, 0, 0, 0);
        send_stat(1'b0, 88);
        step(0, 0, 0, 0);
        check("stat55 stat_q", stat_q, pat_5);

        // sel_dyn during a static burst is a protocol violation.
        fe0 = fe_cnt;
        send_stat(1'b1, 10);
        step(1, 1, 1, 0);
        check("stat violation err", frame_err, 1);
        check("stat violation busy", busy, 0);
        check("stat violation stat_q", stat_q, pat_5);
        step(0, 0, 0, 0);
        check("stat violation pulses", fe_cnt - fe0, 1);

        // HOLD with en_fin and sel_dyn high: frozen, no error.
        send_dyn(32'h1357, 16);
        step(0, 0, 1, 0);
        check("hold dyn_q", dyn_q, 16'h1357);
        fe0 = fe_cnt; dv0 = dv_cnt;
        for (int i = 0; i < 128; i++) step(1'($urandom_range(1)), 1, 0, 1);
        check("hold busy", busy, 1);
        check("hold dyn_q stable", dyn_q, 16'h1357);
        check("hold no err", fe_cnt - fe0, 0);
        check("hold no valid", dv_cnt - dv0, 0);
        step(0, 0, 0, 0);
        check("hold exit busy", busy, 0);

        // Watchdog: no en_fin for 255 HOLD cycles.
        send_dyn(32'h0F0F, 16);
        step(0, 0, 1, 0);
        fe0 = fe_cnt;
        for (int i = 0; i < 254; i++) step(0, 1, 0, 0);
        check("wd 254 busy", busy, 1);
        check("wd 254 no err", fe_cnt - fe0, 0);
        step(0, 1, 0, 0);
        check("wd 255 err", frame_err, 1);
        check("wd 255 busy", busy, 0);
        check("wd dyn_q kept", dyn_q, 16'h0F0F);
        step(0, 0, 0, 0);

        // Reset in the middle of a dynamic burst.
        send_dyn(32'h12, 8);
        #2 RST_N = 1'b0;
        #1;
        check("midreset dyn_q", dyn_q, 0);
        check("midreset stat_q", stat_q, 0);
        check("midreset busy", busy, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        RST_N = 1'b1;
        fe0 = fe_cnt; dv0 = dv_cnt;
        send_dyn(32'h1234, 16);
        step(0, 0, 1, 0);
        check("postreset dyn_q", dyn_q, 16'h1234);
        check("postreset valid", dyn_valid, 1);
        step(0, 0, 0, 0);
        check("postreset no err", fe_cnt - fe0, 0);
        check("postreset pulses", dv_cnt - dv0, 1);

        // Back-to-back dynamic frames with a one-cycle gap.
        dv0 = dv_cnt;
        send_dyn(32'hFFFF, 16);
        step(0, 0, 1, 0);
        check("b2b first dyn_q", dyn_q, 16'hFFFF);
        step(0, 0, 0, 0);
        send_dyn(32'h0000, 16);
        step(0, 0, 1, 0);
        check("b2b second dyn_q", dyn_q, 16'h0000);
        step(0, 0, 0, 0);
        check("b2b pulses", dv_cnt - dv0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
